// File: rtl/led_chase_checker.sv
// led_chase_checker: monitors the one-hot LED chaser bus for step order, wrap, dwell and pattern faults.
// Optional LED_CHK_DIR_EN also accepts right-rotate chasing and adds a dir output.
module led_chase_checker #(
  parameter int WIDTH = 8,
  parameter int POS_W = 3,
  parameter int DWELL = 3,
  parameter int LAP_W = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             tick,
  input  logic [WIDTH-1:0] led,
  output logic [POS_W-1:0] pos,
  output logic             pos_valid,
  output logic             locked,
  output logic             step,
  output logic             lap,
  output logic [LAP_W-1:0] lap_count,
  output logic             err,
  output logic [1:0]       err_code,
  output logic             err_sticky
`ifdef LED_CHK_DIR_EN
  ,
  output logic             dir
`endif
);
  localparam int DW = $clog2(DWELL + 2);
  typedef enum logic [1:0] {IDLE, ACQUIRE, TRACK} state_t;
  state_t state, state_n;
  logic [POS_W-1:0] idx, pos_n, pos_fwd;
  logic [DW-1:0] dwell, dwell_n, dwell_inc;
  logic [LAP_W-1:0] lap_count_n;
  logic [1:0] err_code_n;
  logic multi, onehot, same, fwd, legal, wrong_dir, acq_step, wrap, timed;
  logic pos_valid_n, step_n, lap_n, err_n;
`ifdef LED_CHK_DIR_EN
  logic [POS_W-1:0] pos_rev;
  logic rev, dir_n;
  assign pos_rev = pos == '0 ? POS_W'(WIDTH - 1) : pos - 1'b1;
  assign rev = onehot && idx == pos_rev;
  assign legal = dir ? rev : fwd;
  assign wrong_dir = dir ? fwd : rev;
  assign acq_step = fwd || rev;
  assign wrap = dir ? pos == '0 : pos == POS_W'(WIDTH - 1);
`else
  assign legal = fwd;
  assign wrong_dir = 1'b0;
  assign acq_step = fwd;
  assign wrap = pos == POS_W'(WIDTH - 1);
`endif
  always_comb begin
    idx = '0;
    for (int i = 0; i < WIDTH; i++) if (led[i]) idx = POS_W'(i);
  end
  assign multi = |(led & (led - WIDTH'(1)));
  assign onehot = |led && !multi;
  assign pos_fwd = pos == POS_W'(WIDTH - 1) ? '0 : pos + 1'b1;
  assign same = onehot && idx == pos;
  assign fwd = onehot && idx == pos_fwd;
  assign dwell_inc = dwell == DW'(DWELL + 1) ? dwell : dwell + 1'b1;
  assign timed = dwell == DW'(DWELL);
  assign locked = state == TRACK;
  always_comb begin
    state_n = state;
    pos_n = pos;
    pos_valid_n = pos_valid;
    dwell_n = dwell;
    lap_count_n = lap_count;
    err_code_n = err_code;
    step_n = 1'b0;
    lap_n = 1'b0;
    err_n = 1'b0;
`ifdef LED_CHK_DIR_EN
    dir_n = dir;
`endif
    if (tick) begin
      case (state)
        IDLE: begin
          if (multi) begin
            err_n = 1'b1;
            err_code_n = 2'd1;
          end else if (onehot) begin
            state_n = ACQUIRE;
            pos_n = idx;
            pos_valid_n = 1'b1;
            dwell_n = DW'(1);
          end
        end
        ACQUIRE: begin
          if (multi || !onehot) begin
            state_n = IDLE;
            pos_valid_n = 1'b0;
            err_n = multi;
            err_code_n = multi ? 2'd1 : err_code;
          end else if (same) begin
            dwell_n = dwell_inc;
          end else if (acq_step) begin
            // phase of the first dwell is unknown, so it is not timed
            state_n = TRACK;
            step_n = 1'b1;
            pos_n = idx;
            dwell_n = DW'(1);
            lap_count_n = '0;
`ifdef LED_CHK_DIR_EN
            dir_n = !fwd;
`endif
          end else begin
            err_n = 1'b1;
            err_code_n = 2'd2;
            pos_n = idx;
            dwell_n = DW'(1);
          end
        end
        TRACK: begin
          if (multi || !onehot) begin
            state_n = IDLE;
            pos_valid_n = 1'b0;
            err_n = 1'b1;
            err_code_n = multi ? 2'd1 : 2'd2;
          end else if (same) begin
            dwell_n = timed ? DW'(1) : dwell_inc;
            state_n = timed ? ACQUIRE : TRACK;
            err_n = timed;
            err_code_n = timed ? 2'd3 : err_code;
          end else if (legal) begin
            step_n = 1'b1;
            pos_n = idx;
            dwell_n = DW'(1);
            err_n = !timed;
            err_code_n = timed ? err_code : 2'd3;
            lap_n = wrap;
            lap_count_n = wrap ? lap_count + 1'b1 : lap_count;
          end else begin
            err_n = 1'b1;
            err_code_n = 2'd2;
            state_n = ACQUIRE;
            pos_n = idx;
            dwell_n = DW'(1);
          end
          if (wrong_dir) state_n = ACQUIRE;
        end
        default: state_n = IDLE;
      endcase
    end
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      pos <= '0;
      pos_valid <= 1'b0;
      dwell <= '0;
      step <= 1'b0;
      lap <= 1'b0;
      lap_count <= '0;
      err <= 1'b0;
      err_code <= 2'd0;
      err_sticky <= 1'b0;
    end else begin
      state <= state_n;
      pos <= pos_n;
      pos_valid <= pos_valid_n;
      dwell <= dwell_n;
      step <= step_n;
      lap <= lap_n;
      lap_count <= lap_count_n;
      err <= err_n;
      err_code <= err_code_n;
      err_sticky <= err_sticky | err_n;
    end
  end
`ifdef LED_CHK_DIR_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) dir <= 1'b0;
    else dir <= dir_n;
  end
`endif
endmodule

// File: tb/tb_led_chase_checker.sv
// tb_led_chase_checker: vector table plus scoreboard bench for led_chase_checker (default build).
module tb_led_chase_checker;
  logic clk = 1'b0, rst_n = 1'b0, tick = 1'b0;
  logic [7:0] led = '0;
  logic [2:0] pos;
  logic pos_valid, locked, step, lap, err, err_sticky;
  logic [7:0] lap_count;
  logic [1:0] err_code;
  int tests = 0, fails = 0, steps_obs = 0, steps_exp = 0;
  always #5 clk = ~clk;
  led_chase_checker dut (
    .clk(clk), .rst_n(rst_n), .tick(tick), .led(led), .pos(pos), .pos_valid(pos_valid),
    .locked(locked), .step(step), .lap(lap), .lap_count(lap_count), .err(err),
    .err_code(err_code), .err_sticky(err_sticky)
  );
  typedef struct {
    string name;
    logic [7:0] led;
    logic [18:0] exp;
  } vec_t;
  vec_t vecs[$];
  logic [18:0] sb[$];
  wire [18:0] obs = {pos, pos_valid, locked, step, lap, lap_count, err, err_code, err_sticky};
  function automatic logic [18:0] e(int p, int pv, int lk, int st, int lp, int lc, int er, int cd, int sk);
    return {3'(p), 1'(pv), 1'(lk), 1'(st), 1'(lp), 8'(lc), 1'(er), 2'(cd), 1'(sk)};
  endfunction
  function automatic void add(string n, logic [7:0] l, logic [18:0] x);
    vecs.push_back('{n, l, x});
  endfunction
  task automatic check(string n);
    logic [18:0] x;
    x = sb.pop_front();
    tests++;
    if (obs !== x) begin
      fails++;
      $display("FAIL %s: got pos/pv/lk/st/lap/lc/err/code/sticky=%h expected %h", n, obs, x);
    end
  endtask
  task automatic apply(string n, logic [7:0] l, logic [18:0] x);
    @(negedge clk);
    led = l;
    tick = 1'b1;
    sb.push_back(x);
    @(posedge clk);
    #1;
    tick = 1'b0;
    steps_obs += int'(step);
    steps_exp += int'(x[13]);
    check(n);
  endtask
  initial begin
    int lc;
    lc = 0;
    repeat (3) add("acquire", 8'h01, e(0, 1, 0, 0, 0, 0, 0, 0, 0));
    add("first_step", 8'h02, e(1, 1, 1, 1, 0, 0, 0, 0, 0));
    repeat (2) add("hold", 8'h02, e(1, 1, 1, 0, 0, 0, 0, 0, 0));
    for (int k = 2; k < 17; k++) begin
      int p;
      p = k % 8;
      if (p == 0) lc++;
      add(p == 0 ? "lap_wrap" : "lap_step", 8'h01 << p, e(p, 1, 1, 1, p == 0, lc, 0, 0, 0));
      repeat (2) add("lap_hold", 8'h01 << p, e(p, 1, 1, 0, 0, lc, 0, 0, 0));
    end
    add("pre_stall", 8'h02, e(1, 1, 1, 1, 0, 2, 0, 0, 0));
    repeat (2) add("pre_stall_hold", 8'h02, e(1, 1, 1, 0, 0, 2, 0, 0, 0));
    add("pre_stall", 8'h04, e(2, 1, 1, 1, 0, 2, 0, 0, 0));
    repeat (2) add("pre_stall_hold", 8'h04, e(2, 1, 1, 0, 0, 2, 0, 0, 0));
    add("stall", 8'h04, e(2, 1, 0, 0, 0, 2, 1, 3, 1));
    add("relock", 8'h08, e(3, 1, 1, 1, 0, 0, 0, 3, 1));
    add("seq_jump", 8'h20, e(5, 1, 0, 0, 0, 0, 1, 2, 1));
    add("dark_acq", 8'h00, e(5, 0, 0, 0, 0, 0, 0, 2, 1));
    add("multi_idle", 8'h18, e(5, 0, 0, 0, 0, 0, 1, 1, 1));
    add("reacq", 8'h01, e(0, 1, 0, 0, 0, 0, 0, 1, 1));
    for (int p = 1; p < 4; p++) begin
      add("short_setup", 8'h01 << p, e(p, 1, 1, 1, 0, 0, 0, 1, 1));
      repeat (2) add("short_hold", 8'h01 << p, e(p, 1, 1, 0, 0, 0, 0, 1, 1));
    end
    add("short_setup", 8'h10, e(4, 1, 1, 1, 0, 0, 0, 1, 1));
    add("short_hold", 8'h10, e(4, 1, 1, 0, 0, 0, 0, 1, 1));
    add("short_dwell", 8'h20, e(5, 1, 1, 1, 0, 0, 1, 3, 1));
    add("multi_track", 8'h60, e(5, 0, 0, 0, 0, 0, 1, 1, 1));
    #12;
    sb.push_back(e(0, 0, 0, 0, 0, 0, 0, 0, 0));
    check("reset");
    @(negedge clk);
    rst_n = 1'b1;
    foreach (vecs[i]) apply(vecs[i].name, vecs[i].led, vecs[i].exp);
    tests++;
    if (steps_obs != steps_exp) begin
      fails++;
      $display("FAIL step_total: got %0d expected %0d", steps_obs, steps_exp);
    end
    @(negedge clk);
    led = 8'h40;
    repeat (2) @(posedge clk);
    #1;
    sb.push_back(e(5, 0, 0, 0, 0, 0, 0, 1, 1));
    check("tick_low");
    apply("mid_acq", 8'h01, e(0, 1, 0, 0, 0, 0, 0, 1, 1));
    apply("mid_lock", 8'h02, e(1, 1, 1, 1, 0, 0, 0, 1, 1));
    @(negedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    sb.push_back(e(0, 0, 0, 0, 0, 0, 0, 0, 0));
    check("async_rst");
    @(negedge clk);
    rst_n = 1'b1;
    apply("post_rst", 8'h04, e(2, 1, 0, 0, 0, 0, 0, 0, 0));
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule

// File: doc/led_chase_checker.md
Name: led_chase_checker

Overview:
- Receive-side monitor for the 8-LED running-light chaser.
- Samples the one-hot LED bus on each step strobe, decodes the lit position and checks that the light advances exactly one place per step with wrap-around.
- Checks that the light dwells exactly DWELL strobes per position.
- Reports position, step and lap events, and error codes, for bench self-checking and on-board fault flagging.

Parameters:
- WIDTH, 8: number of LEDs on the bus.
- POS_W, 3: width of the position index; must be at least clog2(WIDTH).
- DWELL, 3: expected number of tick samples per lit position (chaser divide ratio).
- LAP_W, 8: width of the lap counter.

Ports:
- clk  in  1  system clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- tick  in  1  sample strobe, one clk wide; the LED bus is evaluated only when tick=1.
- led  in  WIDTH  LED bus, bit 0 = first LED.
- pos  out  POS_W  index of the lit LED.
- pos_valid  out  1  pos holds a decoded one-hot value.
- locked  out  1  high while state is TRACK.
- step  out  1  one-clk pulse: a legal advance was accepted.
- lap  out  1  one-clk pulse: a legal wrap from the last LED to the first.
- lap_count  out  LAP_W  number of laps since lock; wraps at 2^LAP_W.
- err  out  1  one-clk pulse on any detected fault.
- err_code  out  2  cause of the last err: 1=BAD_PATTERN (more than one bit set), 2=SEQ (illegal next pattern or all-dark while tracking), 3=TIMING (dwell mismatch or stall).
- err_sticky  out  1  set on the first err; cleared only by reset.

Behaviour:
- Reset (async, rst_n=0): all outputs 0; state IDLE; dwell counter 0.
- All outputs are registered and update on the clk edge that samples tick=1 (one-clk latency). With tick=0, state and levels hold and pulses are 0.
- Expected next pattern: rotate led left by 1, so bit WIDTH-1 wraps to bit 0. In the check against the current pattern, the current position is pos.
- Dwell counter: set to 1 on entry to a position, incremented on each tick that sees the same pattern, and saturates at DWELL+1.
- IDLE:
  - led=0: stay.
  - one-hot: go to ACQUIRE; pos = index; pos_valid=1; dwell=1.
  - multi-hot: err, code 1; stay IDLE.
- ACQUIRE:
  - same pattern: dwell++.
  - expected next: go to TRACK; step=1; pos updates; dwell=1. The first dwell is not timed because its phase is unknown.
  - any other one-hot: err, code 2; re-acquire at the new position with dwell=1.
  - multi-hot: err, code 1; go to IDLE; pos_valid=0.
  - zero: go to IDLE; pos_valid=0; no error.
- TRACK:
  - same pattern and dwell<DWELL: dwell++.
  - same pattern and dwell=DWELL (stall): err, code 3; go to ACQUIRE; dwell=1.
  - expected next and dwell=DWELL: step=1; dwell=1; if wrap, lap=1 and lap_count++.
  - expected next and dwell≠DWELL: step=1 and err with code 3 in the same clock; stay in TRACK; dwell=1; lap is handled as normal.
  - other one-hot: err, code 2; go to ACQUIRE at the new position.
  - zero: err, code 2; go to IDLE; pos_valid=0.
  - multi-hot: err, code 1; go to IDLE; pos_valid=0.
- Leaving TRACK does not clear lap_count. lap_count clears only on reset or on entry to TRACK from ACQUIRE.
- err_code holds its value until the next err.
- Reset asserted mid-operation clears immediately, regardless of tick.

Optional Feature:
- LED_CHK_DIR_EN defined:
  - A right-rotate step (bit 0 wraps to bit WIDTH-1) is also legal.
  - The direction is learned on the ACQUIRE→TRACK step and held until TRACK exits.
  - In TRACK, a step in the opposite direction gives err code 2 and goes to ACQUIRE.
  - A right wrap raises lap.
  - An extra output port, dir (1 bit, 0=left, 1=right, reset 0), is present.
- Not defined: left rotation only; right steps give code 2; no dir port.

Test Plan:
- Reset; led=0x01 for 3 ticks, then 0x02 for 3 ticks, then 0x04 → first step at the 0x02 sample; locked=1; pos=2 after the 0x04 sample; no err.
- Locked; run 0x01→…→0x80→0x01, 3 ticks each → lap=1 exactly on the 0x01 sample; lap_count=1; 8 step pulses per lap.
- Locked at 0x04; hold 0x04 for 4 ticks → err code 3 on the 4th tick; locked=0; err_sticky=1.
- Locked at 0x08; next sample 0x20 → err code 2; state ACQUIRE; pos=5. Sample 0x18 from IDLE → err code 1; pos_valid=0.
- Locked; 0x10 for only 2 ticks, then 0x20 → step and err (code 3) in the same clock; locked stays 1.
- Assert rst_n=0 mid-lap between clk edges → all outputs 0 without a clk edge; err_sticky=0. Run with LED_CHK_DIR_EN: 0x01→0x80 → dir=1; lap=1.
